data_store_buffer: RTL and testbench
====================================

# data_store_buffer

Store buffer and request sequencer between the CPU memory stage and `data_mem`. Stores are posted into a small FIFO and retire to `data_mem` in the background, so the CPU does not stall on them. Loads wait until the FIFO has drained, then run one `data_mem` transaction. The block drives `data_mem`'s request pins and tracks its `clk_stall` handshake.

## Interface
- `DEPTH`, 4: store FIFO entries. Must be a power of two, 2..16.
- `clk`  in  1  system clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `cpu_addr`  in  32  byte address from the memory stage
- `cpu_write_data`  in  32  store data, right-aligned
- `cpu_memwrite`  in  1  store request; held while `cpu_stall`=1
- `cpu_memread`  in  1  load request; held while `cpu_stall`=1
- `cpu_sign_mask`  in  4  access size/sign code, passed through unchanged
- `cpu_read_data`  out  32  load result, registered
- `cpu_stall`  out  1  freeze memory stage (combinational from `cpu_mem*` and state)
- `mem_addr`, `mem_write_data`  out  32 each  to `data_mem` `addr` / `write_data`, registered
- `mem_memwrite`, `mem_memread`  out  1 each  to `data_mem`, registered, single-cycle pulses
- `mem_sign_mask`  out  4  to `data_mem` `sign_mask`, registered
- `mem_read_data`  in  32  from `data_mem` `read_data`
- `mem_stall`  in  1  from `data_mem` `clk_stall`; 0 means `data_mem` is idle

## Operation
- FIFO entry = {addr[31:0], data[31:0], sign_mask[3:0]}. Write pointer, read pointer and count are all `$clog2(DEPTH)+1` bits; the pointers wrap modulo `DEPTH`.
- Enqueue happens when `cpu_memwrite`=1 and count<`DEPTH`.
  - `cpu_stall`=0 that cycle; the entry is written at the edge.
  - A pop completing in the same cycle does not free a slot for that cycle's enqueue.
- `cpu_stall` = (`cpu_memwrite` & full) | (`cpu_memread` & state≠LDONE).
- `cpu_memread` & `cpu_memwrite` both high is illegal. The block treats it as a load and drops the store. The bench flags it.
- FSM states: IDLE, ISSUE, WAIT, LDONE.
  - IDLE, count>0 and `mem_stall`=0: load the head entry into the `mem_*` registers with `mem_memwrite`=1, set op=ST, go to ISSUE.
  - IDLE, else if `cpu_memread`=1 and `mem_stall`=0: load `cpu_addr`/`cpu_sign_mask` with `mem_memread`=1, set op=LD, go to ISSUE.
  - ISSUE: one cycle with the request pulse high. At the edge, clear `mem_memread`/`mem_memwrite` and go to WAIT.
  - WAIT, `mem_stall`=1: stay in WAIT.
  - WAIT, `mem_stall`=0 and op=ST: pop the head, go to IDLE.
  - WAIT, `mem_stall`=0 and op=LD: `cpu_read_data` <= `mem_read_data`, go to LDONE.
  - LDONE: one cycle with `cpu_stall`=0 for the held load. Go to IDLE.
- Stores issue before loads (strict program order). No load forwarding.
- Address 0x2000 (LED) stores pass through the FIFO like any other store.

## Timing
- Reset values: state=IDLE, count=0, pointers=0, all `mem_*` outputs=0, `cpu_read_data`=0. `cpu_stall` follows its equation.
- Reset mid-transaction: buffered stores are discarded. `data_mem` has no reset and finishes any in-flight access on its own. The IDLE check on `mem_stall`=0 prevents overlap after reset.
- Store transaction: IDLE(c0) → ISSUE(c1) → WAIT(c2, c3, `mem_stall`=1) → WAIT(c4, `mem_stall`=0, pop at edge) → IDLE(c5).
  - Sustained drain rate: one store per 5 cycles.
  - Enqueue latency: 0 stall cycles when not full.
- Load with empty FIFO: `cpu_memread` rises in c0 (IDLE) → ISSUE c1 → WAIT c2–c4 → LDONE c5.
  - `cpu_stall`=1 in c0–c4 and 0 in c5.
  - `cpu_read_data` is valid from c5 until the next load.
- Load with N stores pending: stalls for 5·N cycles more than the empty-FIFO case.
- WAIT must not treat ISSUE-cycle `mem_stall`=0 as completion. Completion is checked only in WAIT, which `mem_stall`=1 always precedes by construction.

## Test plan
- After reset, `lw` from word 0x100 (data_mem preloaded with 0xDEADBEEF): `cpu_stall` is high for exactly 5 cycles, then `cpu_read_data`=0xDEADBEEF.
- Four back-to-back `sw` (0x11, 0x22, 0x33, 0x44 to 0x0/0x4/0x8/0xC) with `DEPTH`=4:
  - `cpu_stall` stays 0 throughout.
  - A 5th `sw` stalls until the first pop (c4 after the first issue).
  - Memory ends up holding all five values in order.
- `sw` 0x12345678 to 0x40, then immediately `lw` 0x40: the load waits for the drain, then returns 0x12345678.
- `sb` 0xAB to 0x41, then `lhu` 0x40: returns 0x0000AB78 (byte merge preserved through the FIFO).
- `sw` 0x5A to 0x2000: `led`=0x5A after the drain completes.
- Deassert `rst_n` for 1 cycle while WAIT is active with 3 stores queued:
  - Outputs return to their reset values immediately; count=0.
  - No `mem_*` request is issued until `mem_stall`=0.
  - The next `lw` returns correct data.

Source files
------------

// File: rtl/data_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : data_store_buffer
// Purpose  : Posted store FIFO plus load sequencer in front of data_mem.
// Revision : 1.0 - initial release
// ============================================================================
module data_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_write_data,
    input  logic        cpu_memwrite,
    input  logic        cpu_memread,
    input  logic [3:0]  cpu_sign_mask,
    output logic [31:0] cpu_read_data,
    output logic        cpu_stall,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_memwrite,
    output logic        mem_memread,
    output logic [3:0]  mem_sign_mask,
    input  logic [31:0] mem_read_data,
    input  logic        mem_stall
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic OP_ST = 1'b0;
    localparam logic OP_LD = 1'b1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_LDONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               op_q, op_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   count_q, count_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [31:0]        mem_write_data_q, mem_write_data_d;
    logic               mem_memwrite_q, mem_memwrite_d;
    logic               mem_memread_q, mem_memread_d;
    logic [3:0]         mem_sign_mask_q, mem_sign_mask_d;
    logic [31:0]        cpu_read_data_q, cpu_read_data_d;

    // Entry layout: {addr[31:0], data[31:0], sign_mask[3:0]}
    logic [67:0]        fifo_q [DEPTH];
    logic [67:0]        head;
    logic [IDX_W-1:0]   wr_idx;
    logic [IDX_W-1:0]   rd_idx;
    logic               full;
    logic               push;
    logic               pop;

    assign wr_idx = wr_ptr_q[IDX_W-1:0];
    assign rd_idx = rd_ptr_q[IDX_W-1:0];

    // A simultaneous load+store is served as a load; the store is dropped.
    always_comb begin
        full      = (count_q == PTR_W'(DEPTH));
        push      = cpu_memwrite && !cpu_memread && !full;
        cpu_stall = (cpu_memwrite && full) || (cpu_memread && (state_q != S_LDONE));
        head      = fifo_q[rd_idx];
    end

    always_comb begin
        state_d          = state_q;
        op_d             = op_q;
        mem_addr_d       = mem_addr_q;
        mem_write_data_d = mem_write_data_q;
        mem_sign_mask_d  = mem_sign_mask_q;
        mem_memwrite_d   = 1'b0;
        mem_memread_d    = 1'b0;
        cpu_read_data_d  = cpu_read_data_q;
        pop              = 1'b0;

        case (state_q)
            S_IDLE: begin
                // Buffered stores always go first to keep program order.
                if ((count_q != '0) && !mem_stall) begin
                    mem_addr_d       = head[67:36];
                    mem_write_data_d = head[35:4];
                    mem_sign_mask_d  = head[3:0];
                    mem_memwrite_d   = 1'b1;
                    op_d             = OP_ST;
                    state_d          = S_ISSUE;
                end else if (cpu_memread && !mem_stall) begin
                    mem_addr_d       = cpu_addr;
                    mem_sign_mask_d  = cpu_sign_mask;
                    mem_memread_d    = 1'b1;
                    op_d             = OP_LD;
                    state_d          = S_ISSUE;
                end
            end
            S_ISSUE: begin
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (!mem_stall) begin
                    if (op_q == OP_ST) begin
                        pop     = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        cpu_read_data_d = mem_read_data;
                        state_d         = S_LDONE;
                    end
                end
            end
            S_LDONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            op_q             <= OP_ST;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            count_q          <= '0;
            mem_addr_q       <= '0;
            mem_write_data_q <= '0;
            mem_memwrite_q   <= 1'b0;
            mem_memread_q    <= 1'b0;
            mem_sign_mask_q  <= '0;
            cpu_read_data_q  <= '0;
        end else begin
            state_q          <= state_d;
            op_q             <= op_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            count_q          <= count_d;
            mem_addr_q       <= mem_addr_d;
            mem_write_data_q <= mem_write_data_d;
            mem_memwrite_q   <= mem_memwrite_d;
            mem_memread_q    <= mem_memread_d;
            mem_sign_mask_q  <= mem_sign_mask_d;
            cpu_read_data_q  <= cpu_read_data_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_idx] <= {cpu_addr, cpu_write_data, cpu_sign_mask};
        end
    end

    assign mem_addr       = mem_addr_q;
    assign mem_write_data = mem_write_data_q;
    assign mem_memwrite   = mem_memwrite_q;
    assign mem_memread    = mem_memread_q;
    assign mem_sign_mask  = mem_sign_mask_q;
    assign cpu_read_data  = cpu_read_data_q;

endmodule
`default_nettype wire

// File: tb/tb_data_store_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_store_buffer
// Purpose  : Bench for data_store_buffer with a data_mem model and scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_store_buffer;

    localparam int DEPTH = 4;
    // sign_mask code: [1:0] size (0 byte, 1 half, 2 word), [2] zero-extend
    localparam logic [3:0] SM_B  = 4'b0000;
    localparam logic [3:0] SM_HU = 4'b0101;
    localparam logic [3:0] SM_W  = 4'b0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_write_data = '0;
    logic        cpu_memwrite = 1'b0;
    logic        cpu_memread = 1'b0;
    logic [3:0]  cpu_sign_mask = '0;
    logic [31:0] cpu_read_data;
    logic        cpu_stall;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic        mem_memwrite;
    logic        mem_memread;
    logic [3:0]  mem_sign_mask;
    logic [31:0] mem_read_data = '0;
    logic        mem_stall;

    int checks = 0;
    int failures = 0;

    data_store_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
        .cpu_memwrite(cpu_memwrite), .cpu_memread(cpu_memread),
        .cpu_sign_mask(cpu_sign_mask), .cpu_read_data(cpu_read_data),
        .cpu_stall(cpu_stall), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
        .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
        .mem_stall(mem_stall)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] a,
                                          input logic [31:0] d, input logic [3:0] m);
        logic [31:0] r = w;
        case (m[1:0])
            2'd0:    r[8*a[1:0] +: 8] = d[7:0];
            2'd1:    r[16*a[1] +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] a,
                                             input logic [3:0] m);
        logic [7:0]  b = w[8*a[1:0] +: 8];
        logic [15:0] h = w[16*a[1] +: 16];
        case (m[1:0])
            2'd0:    return m[2] ? {24'b0, b} : {{24{b[7]}}, b};
            2'd1:    return m[2] ? {16'b0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    // data_mem model (no reset): request seen at an edge -> clk_stall for two
    // cycles, access lands at the end of the second, idle the cycle after.
    logic [31:0] dm_mem  [0:4095];
    logic [31:0] ref_mem [0:4095];
    logic [31:0] led = '0;
    int          dm_cnt = 0;
    logic [1:0]  dm_op = 2'd0;          // 0 none, 1 write, 2 read
    logic        dm_orphan = 1'b0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wd = '0;
    logic [3:0]  dm_mask = '0;
    assign mem_stall = (dm_cnt != 0);

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  m;
    } st_t;
    st_t  exp_q[$];
    int   m_count = 0;
    logic ld_done = 1'b0;
    logic prev_req = 1'b0;

    always @(posedge clk) begin
        ld_done = 1'b0;
        if (dm_cnt == 1) begin
            if (dm_op == 2'd1) begin
                dm_mem[dm_addr[13:2]] = merge(dm_mem[dm_addr[13:2]], dm_addr, dm_wd, dm_mask);
                if (dm_addr == 32'h2000) led = dm_wd;
            end else begin
                mem_read_data <= load_val(dm_mem[dm_addr[13:2]], dm_addr, dm_mask);
            end
        end
        if (!rst_n) begin
            // Queued stores are lost; an in-flight write still lands.
            for (int i = 0; i < 4096; i++) ref_mem[i] = dm_mem[i];
            if (dm_op == 2'd1 && dm_cnt == 2)
                ref_mem[dm_addr[13:2]] = merge(ref_mem[dm_addr[13:2]], dm_addr, dm_wd, dm_mask);
            exp_q.delete();
            m_count = 0;
            if (dm_op != 2'd0) dm_orphan = 1'b1;
        end else if (cpu_memwrite && !cpu_memread && m_count < DEPTH) begin
            exp_q.push_back('{cpu_addr, cpu_write_data, cpu_sign_mask});
            ref_mem[cpu_addr[13:2]] = merge(ref_mem[cpu_addr[13:2]], cpu_addr, cpu_write_data, cpu_sign_mask);
            m_count++;
        end
        if (dm_op != 2'd0 && dm_cnt == 0) begin
            if (!dm_orphan && rst_n) begin
                if (dm_op == 2'd1) m_count--;
                else ld_done = 1'b1;
            end
            dm_op = 2'd0;
            dm_orphan = 1'b0;
        end
        if (mem_memwrite || mem_memread) begin
            dm_op   = mem_memwrite ? 2'd1 : 2'd2;
            dm_addr = mem_addr;
            dm_wd   = mem_write_data;
            dm_mask = mem_sign_mask;
            dm_cnt <= 2;
        end else if (dm_cnt != 0) begin
            dm_cnt <= dm_cnt - 1;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_req = 1'b0;
        end else begin
            check("cpu_stall", 32'(cpu_stall),
                  32'((cpu_memwrite && m_count == DEPTH) || (cpu_memread && !ld_done)));
            if (cpu_memread && ld_done)
                check("load_data", cpu_read_data,
                      load_val(ref_mem[cpu_addr[13:2]], cpu_addr, cpu_sign_mask));
            if (mem_memwrite || mem_memread) begin
                check("req_while_busy", 32'(dm_op), 32'd0);
                check("req_pulse_width", 32'(prev_req), 32'd0);
                check("req_onehot", 32'(mem_memwrite && mem_memread), 32'd0);
            end
            if (mem_memwrite) begin
                check("store_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    check("st_addr", mem_addr, exp_q[0].a);
                    check("st_data", mem_write_data, exp_q[0].d);
                    check("st_mask", 32'(mem_sign_mask), 32'(exp_q[0].m));
                    void'(exp_q.pop_front());
                end
            end
            if (mem_memread) begin
                check("load_after_drain", 32'(exp_q.size()), 32'd0);
                check("ld_addr", mem_addr, cpu_addr);
                check("ld_mask", 32'(mem_sign_mask), 32'(cpu_sign_mask));
            end
            prev_req = mem_memwrite || mem_memread;
            if (cpu_memread && cpu_memwrite)
                $display("note: load and store asserted together at %0t; store is dropped", $time);
        end
    end

    task automatic do_sw(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m,
                         output int stalls);
        cpu_addr = a; cpu_write_data = d; cpu_sign_mask = m;
        cpu_memwrite = 1'b1; cpu_memread = 1'b0; stalls = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        check("sw_timeout", 32'(cpu_stall), 32'd0);
        @(posedge clk); #1;
        cpu_memwrite = 1'b0;
    endtask

    task automatic do_lw(input logic [31:0] a, input logic [3:0] m, input logic wr_too,
                         output logic [31:0] data, output int stalls);
        cpu_addr = a; cpu_sign_mask = m;
        cpu_memread = 1'b1; cpu_memwrite = wr_too; stalls = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        check("lw_timeout", 32'(cpu_stall), 32'd0);
        data = cpu_read_data;
        @(posedge clk); #1;
        cpu_memread = 1'b0; cpu_memwrite = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((m_count != 0 || dm_op != 2'd0) && n < 200) begin
            n++;
            @(posedge clk); #1;
        end
        check("drain_timeout", 32'(m_count != 0 || dm_op != 2'd0), 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #500000;
        failures++;
        $display("FAIL watchdog: got no completion want finish by 500000");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [31:0] d;
        int          s;
        for (int i = 0; i < 4096; i++) begin
            dm_mem[i] = '0;
            ref_mem[i] = '0;
        end
        dm_mem[32'h100 >> 2]  = 32'hDEADBEEF;
        ref_mem[32'h100 >> 2] = 32'hDEADBEEF;

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wd", mem_write_data, 32'h0);
        check("rst_mem_req", 32'({mem_memwrite, mem_memread}), 32'd0);
        check("rst_mem_mask", 32'(mem_sign_mask), 32'd0);
        check("rst_rd_data", cpu_read_data, 32'h0);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        rst_n = 1'b1;

        do_lw(32'h100, SM_W, 1'b0, d, s);
        check("lw_empty_stall", 32'(s), 32'd5);
        check("lw_empty_data", d, 32'hDEADBEEF);

        for (int i = 0; i < 4; i++) begin
            do_sw(32'(i * 4), 32'(8'h11 * (i + 1)), SM_W, s);
            check("sw_burst_stall", 32'(s), 32'd0);
        end
        do_sw(32'h10, 32'h55, SM_W, s);
        check("sw_full_stall", 32'(s), 32'd2);
        wait_drain();
        for (int i = 0; i < 5; i++)
            check("drain_order", dm_mem[i], 32'(8'h11 * (i + 1)));

        do_sw(32'h40, 32'h12345678, SM_W, s);
        do_lw(32'h40, SM_W, 1'b0, d, s);
        check("sw_lw_stall", 32'(s), 32'd10);
        check("sw_lw_data", d, 32'h12345678);

        do_sw(32'h41, 32'hAB, SM_B, s);
        do_lw(32'h40, SM_HU, 1'b0, d, s);
        check("sb_lhu_data", d, 32'h0000AB78);

        do_sw(32'h2000, 32'h5A, SM_W, s);
        wait_drain();
        check("led", led, 32'h5A);

        cpu_write_data = 32'h99;
        do_lw(32'h100, SM_W, 1'b1, d, s);
        check("illegal_ld_data", d, 32'hDEADBEEF);
        do_lw(32'h100, SM_W, 1'b0, d, s);
        check("illegal_st_dropped", d, 32'hDEADBEEF);

        for (int i = 0; i < 3; i++)
            do_sw(32'h200 + 32'(i * 4), 32'hA1 + 32'(i), SM_W, s);
        rst_n = 1'b0;
        #1;
        check("midrst_mem_addr", mem_addr, 32'h0);
        check("midrst_mem_wd", mem_write_data, 32'h0);
        check("midrst_mem_req", 32'({mem_memwrite, mem_memread}), 32'd0);
        check("midrst_mem_mask", 32'(mem_sign_mask), 32'd0);
        check("midrst_rd_data", cpu_read_data, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_lw(32'h200, SM_W, 1'b0, d, s);
        check("postrst_stall", 32'(s), 32'd6);
        check("postrst_inflight", d, 32'hA1);
        do_lw(32'h204, SM_W, 1'b0, d, s);
        check("postrst_discarded", d, 32'h0);

        wait_drain();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
